spm_arbiter: RTL and testbench

SPM_ARBITER -- requirements
Module: spm_arbiter

---
 rtl/spm_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/spm_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_spm_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_arb_pkg.sv
// Shared types and constants for the scratchpad arbiter.
package spm_arb_pkg;

    localparam int unsigned SPM_WORDS = 8192;
    localparam int unsigned SPM_BYTES = 32768;
    localparam int unsigned SPM_LAT   = 5;
    localparam int unsigned ADDR_WID  = 13;

    typedef enum logic [2:0] {
        ARB,
        SPM_ACC,
        EXT_RD,
        EXT_WR,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    // True when a byte address falls inside the scratchpad window.
    function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base);
        return (addr >= base) && ((addr - base) < 64'(SPM_BYTES));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection with its own pointer register.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic ptr;

    // Pointer breaks ties; a lone requester wins regardless of the pointer.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req[0] && req[1]) begin
            gnt_id = ptr;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

    // Pointer moves to the requester after the one just served.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~served;
        end
    end

endmodule

// File: rtl/spm_arbiter.sv
// Arbitrates kernel requesters onto a scratchpad window or an external port.
module spm_arbiter
    import spm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned SPM_LAT  = spm_arb_pkg::SPM_LAT,
    parameter int unsigned ADDR_WID = spm_arb_pkg::ADDR_WID
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           spm_base,
    input  logic [63:0]           read_size_input,
    input  logic [NUM_REQ-1:0]    k_read_enable,
    input  logic [NUM_REQ-1:0]    k_write_enable,
    input  logic [64*NUM_REQ-1:0] k_read_addr,
    input  logic [64*NUM_REQ-1:0] k_write_addr,
    input  logic [32*NUM_REQ-1:0] k_write_data,
    input  logic [NUM_REQ-1:0]    k_done,
    output logic [NUM_REQ-1:0]    k_read_ready,
    output logic [NUM_REQ-1:0]    k_write_ready,
    output logic [32*NUM_REQ-1:0] k_read_data,
    output logic                  spm_ce,
    output logic                  spm_we,
    output logic [ADDR_WID-1:0]   spm_addr,
    output logic [31:0]           spm_d,
    input  logic [31:0]           spm_q,
    output logic                  read_enable,
    output logic                  write_enable,
    output logic [63:0]           read_addr,
    output logic [63:0]           write_addr,
    output logic [31:0]           write_data,
    output logic [63:0]           read_size_output,
    output logic [63:0]           write_size,
    input  logic [63:0]           read_ready,
    input  logic [63:0]           write_ready,
    output logic                  done
);

    localparam int unsigned LAT_W = $clog2(SPM_LAT + 1);

    state_t             state;
    logic [LAT_W-1:0]   cnt;
    op_t                op;
    logic               id;
    logic               mask_valid;
    logic               mask_id;
    logic [NUM_REQ-1:0] seen;
    logic [NUM_REQ-1:0] eligible;
    logic               gnt_valid;
    logic               gnt_id;
    logic               sel_rd;
    logic [63:0]        sel_addr;
    logic [63:0]        sel_off;
    logic [31:0]        sel_data;
    logic               sel_hit;

    // Requesters with a pending op, minus the one served in the last RESP.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = (k_read_enable[i] | k_write_enable[i]) && (state == ARB)
                          && !(mask_valid && (mask_id == 1'(i)));
        end
    end

    rr_arb2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (eligible),
        .advance   (state == RESP),
        .served    (id),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Op, address and data of the granted requester; read wins over write.
    always_comb begin
        sel_rd   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == 1'(i)) begin
                sel_rd   = k_read_enable[i];
                sel_addr = k_read_enable[i] ? k_read_addr[64*i +: 64] : k_write_addr[64*i +: 64];
                sel_data = k_write_data[32*i +: 32];
            end
        end
        sel_off = sel_addr - spm_base;
        sel_hit = in_window(sel_addr, spm_base);
    end

    // Transaction FSM; every output is a register loaded on the state change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= ARB;
            cnt              <= '0;
            op               <= OP_RD;
            id               <= 1'b0;
            mask_valid       <= 1'b0;
            mask_id          <= 1'b0;
            spm_ce           <= 1'b0;
            spm_we           <= 1'b0;
            spm_addr         <= '0;
            spm_d            <= '0;
            read_enable      <= 1'b0;
            write_enable     <= 1'b0;
            read_addr        <= '0;
            write_addr       <= '0;
            write_data       <= '0;
            read_size_output <= '0;
            write_size       <= '0;
            k_read_ready     <= '0;
            k_write_ready    <= '0;
            k_read_data      <= '0;
        end else begin
            k_read_ready  <= '0;
            k_write_ready <= '0;
            case (state)
                ARB: begin
                    mask_valid <= 1'b0;
                    if (gnt_valid) begin
                        op <= sel_rd ? OP_RD : OP_WR;
                        id <= gnt_id;
                        if (sel_hit) begin
                            state    <= SPM_ACC;
                            cnt      <= '0;
                            spm_ce   <= 1'b1;
                            spm_we   <= ~sel_rd;
                            spm_addr <= ADDR_WID'(sel_off >> 2);
                            spm_d    <= sel_rd ? '0 : sel_data;
                        end else if (sel_rd) begin
                            state            <= EXT_RD;
                            read_enable      <= 1'b1;
                            read_addr        <= sel_addr;
                            read_size_output <= read_size_input;
                        end else begin
                            state        <= EXT_WR;
                            write_enable <= 1'b1;
                            write_addr   <= sel_addr;
                            write_data   <= sel_data;
                            write_size   <= read_size_input;
                        end
                    end
                end
                SPM_ACC: begin
                    if (cnt == LAT_W'(SPM_LAT - 1)) begin
                        spm_ce <= 1'b0;
                        spm_we <= 1'b0;
                        state  <= RESP;
                        if (op == OP_RD) begin
                            k_read_ready[id]              <= 1'b1;
                            k_read_data[32*int'(id) +: 32] <= spm_q;
                        end else begin
                            k_write_ready[id] <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // External read data returns on the shared spm_q bus.
                EXT_RD: begin
                    if (read_ready == 64'd1) begin
                        read_enable                    <= 1'b0;
                        k_read_ready[id]               <= 1'b1;
                        k_read_data[32*int'(id) +: 32] <= spm_q;
                        state                          <= RESP;
                    end
                end
                EXT_WR: begin
                    if (write_ready == 64'd1) begin
                        write_enable      <= 1'b0;
                        k_write_ready[id] <= 1'b1;
                        state             <= RESP;
                    end
                end
                RESP: begin
                    mask_valid <= 1'b1;
                    mask_id    <= id;
                    state      <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

    // Sticky completion once each k_done bit has been seen high at least once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seen <= '0;
            done <= 1'b0;
        end else begin
            seen <= seen | k_done;
            done <= &(seen | k_done);
        end
    end

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed bench for spm_arbiter with a transaction-level reference model.
module tb_spm_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  spm_base, read_size_input;
    logic [1:0]   k_read_enable, k_write_enable, k_done;
    logic [127:0] k_read_addr, k_write_addr;
    logic [63:0]  k_write_data;
    logic [1:0]   k_read_ready, k_write_ready;
    logic [63:0]  k_read_data;
    logic         spm_ce, spm_we;
    logic [12:0]  spm_addr;
    logic [31:0]  spm_d, spm_q;
    logic         read_enable, write_enable;
    logic [63:0]  read_addr, write_addr;
    logic [31:0]  write_data;
    logic [63:0]  read_size_output, write_size, read_ready, write_ready;
    logic         done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spm_arbiter #(.NUM_REQ(2), .SPM_LAT(5), .ADDR_WID(13)) dut (
        .clk(clk), .reset(reset), .spm_base(spm_base), .read_size_input(read_size_input),
        .k_read_enable(k_read_enable), .k_write_enable(k_write_enable),
        .k_read_addr(k_read_addr), .k_write_addr(k_write_addr), .k_write_data(k_write_data),
        .k_done(k_done), .k_read_ready(k_read_ready), .k_write_ready(k_write_ready),
        .k_read_data(k_read_data), .spm_ce(spm_ce), .spm_we(spm_we), .spm_addr(spm_addr),
        .spm_d(spm_d), .spm_q(spm_q), .read_enable(read_enable), .write_enable(write_enable),
        .read_addr(read_addr), .write_addr(write_addr), .write_data(write_data),
        .read_size_output(read_size_output), .write_size(write_size),
        .read_ready(read_ready), .write_ready(write_ready), .done(done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 choosing, 1 scratchpad countdown, 2 waiting on external, 3 responding
    int          m_mode, m_left, m_id, m_ptr, m_blk, cand;
    bit          m_rd, m_rst, started = 1'b0;
    bit   [1:0]  m_seen, elig;
    logic [63:0] a;
    logic        e_ce, e_we, e_re, e_wre, e_done;
    logic [1:0]  e_krr, e_kwr;
    logic [12:0] e_spm_addr;
    logic [31:0] e_spm_d, e_wdata;
    logic [31:0] e_krd [2];
    logic [63:0] e_raddr, e_waddr, e_rsz, e_wsz;

    always @(posedge clk) begin
        started = 1'b1;
        e_krr = 2'b00;
        e_kwr = 2'b00;
        if (!reset) begin
            m_rst = 1'b1; m_mode = 0; m_ptr = 0; m_blk = -1; m_seen = 2'b00;
            e_done = 1'b0; e_ce = 1'b0; e_we = 1'b0; e_re = 1'b0; e_wre = 1'b0;
        end else begin
            m_rst  = 1'b0;
            m_seen = m_seen | k_done;
            e_done = (m_seen == 2'b11);
            if (m_mode == 0) begin
                for (int r = 0; r < 2; r++)
                    elig[r] = (k_read_enable[r] || k_write_enable[r]) && (r != m_blk);
                cand = -1;
                if (elig == 2'b11) cand = m_ptr;
                else if (elig[0]) cand = 0;
                else if (elig[1]) cand = 1;
                m_blk = -1;
                if (cand >= 0) begin
                    m_id = cand;
                    m_rd = k_read_enable[cand];
                    a = m_rd ? k_read_addr[cand*64 +: 64] : k_write_addr[cand*64 +: 64];
                    if (a >= spm_base && a < spm_base + 64'd32768) begin
                        m_mode = 1; m_left = 5; e_ce = 1'b1; e_we = !m_rd;
                        e_spm_addr = 13'((a - spm_base) / 4);
                        e_spm_d = k_write_data[cand*32 +: 32];
                    end else if (m_rd) begin
                        m_mode = 2; e_re = 1'b1; e_raddr = a; e_rsz = read_size_input;
                    end else begin
                        m_mode = 2; e_wre = 1'b1; e_waddr = a; e_wsz = read_size_input;
                        e_wdata = k_write_data[cand*32 +: 32];
                    end
                end
            end else if (m_mode == 1 || m_mode == 2) begin
                if (m_mode == 1) m_left = m_left - 1;
                if ((m_mode == 1 && m_left == 0) ||
                    (m_mode == 2 && (m_rd ? read_ready == 64'd1 : write_ready == 64'd1))) begin
                    e_ce = 1'b0; e_we = 1'b0; e_re = 1'b0; e_wre = 1'b0; m_mode = 3;
                    if (m_rd) begin e_krr[m_id] = 1'b1; e_krd[m_id] = spm_q; end
                    else e_kwr[m_id] = 1'b1;
                end
            end else begin
                m_blk = m_id; m_ptr = 1 - m_id; m_mode = 0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("spm_ce", spm_ce, e_ce);
            chk("spm_we", spm_we, e_we);
            chk("read_enable", read_enable, e_re);
            chk("write_enable", write_enable, e_wre);
            chk("k_read_ready", k_read_ready, e_krr);
            chk("k_write_ready", k_write_ready, e_kwr);
            chk("done", done, e_done);
            if (e_ce) chk("spm_addr", spm_addr, e_spm_addr);
            if (e_we) chk("spm_d", spm_d, e_spm_d);
            if (e_re) begin
                chk("read_addr", read_addr, e_raddr);
                chk("read_size_output", read_size_output, e_rsz);
            end
            if (e_wre) begin
                chk("write_addr", write_addr, e_waddr);
                chk("write_data", write_data, e_wdata);
                chk("write_size", write_size, e_wsz);
            end
            for (int r = 0; r < 2; r++)
                if (e_krr[r]) chk("k_read_data", k_read_data[r*32 +: 32], e_krd[r]);
            if (m_rst) begin
                chk("rst_spm_addr", spm_addr, 0);
                chk("rst_spm_d", spm_d, 0);
                chk("rst_read_addr", read_addr, 0);
                chk("rst_write_addr", write_addr, 0);
                chk("rst_write_data", write_data, 0);
                chk("rst_read_size", read_size_output, 0);
                chk("rst_write_size", write_size, 0);
                chk("rst_k_read_data", k_read_data, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts negedges from the current cycle until the requested ready pulse.
    task automatic wait_pulse(input int id, input bit rd, input int maxc,
                              output int lat, output int ce_n, output logic [12:0] sa);
        lat = -1; ce_n = 0; sa = '0;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (spm_ce) begin
                if (ce_n == 0) sa = spm_addr;
                ce_n++;
            end
            if (rd ? k_read_ready[id] : k_write_ready[id]) begin
                lat = n;
                break;
            end
        end
    endtask

    int          lat, ce_n;
    logic [12:0] sa;

    initial begin
        reset = 1'b0;
        spm_base = 64'h0000_0000_4000_0000;
        read_size_input = 64'h40;
        k_read_enable = '0; k_write_enable = '0; k_done = '0;
        k_read_addr = '0; k_write_addr = '0; k_write_data = '0;
        spm_q = '0; read_ready = '0; write_ready = '0;
        idle(3);
        @(negedge clk);
        chk("reset_done", done, 0);
        chk("reset_spm_ce", spm_ce, 0);

        // req0 reads spm_base+8 (hit)
        @(posedge clk); #1;
        reset = 1'b1;
        spm_q = 32'h55;
        k_read_addr[63:0] = spm_base + 64'd8;
        k_read_enable[0] = 1'b1;
        wait_pulse(0, 1, 20, lat, ce_n, sa);
        chk("hit_rd_latency", lat, 6);
        chk("hit_rd_ce_cycles", ce_n, 5);
        chk("hit_rd_spm_addr", sa, 2);
        chk("hit_rd_data", k_read_data[31:0], 32'h55);
        idle(1);
        k_read_enable[0] = 1'b0;

        // req0 writes the last window word (hit boundary)
        idle(2);
        k_write_addr[63:0] = spm_base + 64'd32764;
        k_write_data[31:0] = 32'hDEAD_BEEF;
        k_write_enable[0] = 1'b1;
        wait_pulse(0, 0, 20, lat, ce_n, sa);
        chk("hit_wr_latency", lat, 6);
        chk("hit_wr_spm_addr", sa, 13'h1FFF);
        idle(1);
        k_write_enable[0] = 1'b0;

        // both requesters read hits from reset
        idle(1);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        spm_q = 32'hA5A5_0001;
        k_read_addr[63:0]   = spm_base + 64'h10;
        k_read_addr[127:64] = spm_base + 64'h20;
        k_read_enable = 2'b11;
        wait_pulse(0, 1, 20, lat, ce_n, sa);
        chk("rr_first_req0", lat, 6);
        chk("rr_first_addr", sa, 4);
        idle(1);
        k_read_enable[0] = 1'b0;
        wait_pulse(1, 1, 20, lat, ce_n, sa);
        chk("rr_second_req1", lat, 6);
        chk("rr_second_addr", sa, 8);
        idle(1);
        idle(1);
        k_read_enable[1] = 1'b0;
        wait_pulse(1, 1, 8, lat, ce_n, sa);
        chk("mask_no_regrant_ce", ce_n, 0);
        chk("mask_no_regrant_pulse", lat, -1);

        // req1 writes spm_base+32768 (first miss above the window)
        idle(1);
        k_write_addr[127:64] = spm_base + 64'd32768;
        k_write_data[63:32] = 32'hAB;
        k_write_enable[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ext_wr_enable", write_enable, 1);
        chk("ext_wr_addr", write_addr, spm_base + 64'd32768);
        chk("ext_wr_no_ce", spm_ce, 0);
        idle(1);
        idle(1);
        idle(1);
        write_ready = 64'd1;
        idle(1);
        write_ready = 64'd0;
        wait_pulse(1, 0, 4, lat, ce_n, sa);
        chk("ext_wr_pulse", lat, 0);
        idle(1);
        k_write_enable[1] = 1'b0;

        // req0 reads spm_base-4; read_ready==2 must be ignored
        idle(2);
        spm_q = 32'h1234_5678;
        k_read_addr[63:0] = spm_base - 64'd4;
        k_read_enable[0] = 1'b1;
        idle(1);
        read_ready = 64'd2;
        idle(2);
        @(negedge clk);
        chk("ext_rd_wait_on_2", read_enable, 1);
        idle(1);
        read_ready = 64'd1;
        idle(1);
        read_ready = 64'd0;
        wait_pulse(0, 1, 4, lat, ce_n, sa);
        chk("ext_rd_pulse", lat, 0);
        chk("ext_rd_data", k_read_data[31:0], 32'h1234_5678);
        idle(1);
        k_read_enable[0] = 1'b0;

        // reset during EXT_RD
        idle(2);
        k_read_enable[0] = 1'b1;
        idle(1);
        @(negedge clk);
        chk("rst_mid_ext_before", read_enable, 1);
        idle(1);
        reset = 1'b0;
        k_read_enable[0] = 1'b0;
        @(negedge clk);
        idle(1);
        reset = 1'b1;
        chk("rst_mid_ext_dropped", read_enable, 0);
        wait_pulse(0, 1, 8, lat, ce_n, sa);
        chk("rst_mid_ext_no_pulse", lat, -1);

        // done stickiness
        k_done = 2'b01;
        idle(3);
        @(negedge clk);
        chk("done_after_01", done, 0);
        k_done = 2'b00;
        idle(2);
        k_done = 2'b10;
        idle(1);
        k_done = 2'b00;
        @(negedge clk);
        chk("done_after_10", done, 1);
        idle(4);
        chk("done_sticky", done, 1);
        reset = 1'b0;
        idle(2);
        @(negedge clk);
        chk("done_cleared_by_reset", done, 0);
        reset = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
